// File: rtl/car_park_allocator.sv
// car_park_allocator
//
// Parking controller with a per-slot occupancy bitmap. Each entry request is
// granted the lowest-numbered free slot, and each release frees one named
// slot. A granted entry opens the barrier for GATE_CYCLES cycles. Every
// status output is registered.
//
// Optional feature macro: CAR_PARK_RESERVE_EN
//   When it is defined, the top RESERVED_SLOTS indices can only be granted to
//   requests that arrive with i_car_permit high.
//
// Ports:
//   i_clk               clock, rising edge
//   i_reset             synchronous active-high reset
//   i_car_enter         entry request (level), acted on only in IDLE
//   i_car_permit        permit qualifier, sampled with i_car_enter
//                       (exists only with CAR_PARK_RESERVE_EN)
//   i_car_leave         release request, one release per high cycle
//   i_leave_slot        slot index being released
//   o_spot_allocated    one-cycle pulse on a grant
//   o_alloc_slot        granted index, held until the next grant
//   o_enter_denied      one-cycle pulse on a refused request
//   o_leave_error       one-cycle pulse on a release of a free or out-of-range slot
//   o_entry_gate_open   barrier drive
//   o_available_slots   count of free slots
//   o_parking_full      high when no slot is free
//   o_parking_empty     high when every slot is free
//   o_occupancy         bit i set means slot i is occupied
//
// Entry FSM:
//   state      | meaning
//   S_IDLE     | waiting for car_enter; grants or denies on the first one seen
//   S_GATE     | barrier open, gate down-counter running
//   S_WAIT_CLR | waiting for car_enter to drop so that a held request is not re-served

module car_park_allocator #(
  parameter int NUM_SLOTS   = 8,
  parameter int GATE_CYCLES = 4,
`ifdef CAR_PARK_RESERVE_EN
  parameter int RESERVED_SLOTS = 2,
`endif
  localparam int IDX_W = $clog2(NUM_SLOTS),
  localparam int CNT_W = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_car_enter,
`ifdef CAR_PARK_RESERVE_EN
  input  logic                 i_car_permit,
`endif
  input  logic                 i_car_leave,
  input  logic [IDX_W-1:0]     i_leave_slot,
  output logic                 o_spot_allocated,
  output logic [IDX_W-1:0]     o_alloc_slot,
  output logic                 o_enter_denied,
  output logic                 o_leave_error,
  output logic                 o_entry_gate_open,
  output logic [CNT_W-1:0]     o_available_slots,
  output logic                 o_parking_full,
  output logic                 o_parking_empty,
  output logic [NUM_SLOTS-1:0] o_occupancy
);

  localparam int GC_W  = $clog2(GATE_CYCLES + 1);
  localparam int PAD_W = 1 << IDX_W;
`ifdef CAR_PARK_RESERVE_EN
  localparam int GEN_SLOTS = NUM_SLOTS - RESERVED_SLOTS;
`else
  localparam int GEN_SLOTS = NUM_SLOTS;
`endif
  localparam logic [IDX_W:0]   SLOT_LIM  = (IDX_W + 1)'(NUM_SLOTS);
  localparam logic [CNT_W-1:0] ALL_FREE  = CNT_W'(NUM_SLOTS);
  localparam logic [GC_W-1:0]  GATE_LOAD = GC_W'(GATE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GATE     = 2'd1,
    S_WAIT_CLR = 2'd2
  } state_t;

  state_t                r_state;
  logic [GC_W-1:0]       r_gate_cnt;
  logic [NUM_SLOTS-1:0]  r_occ;
  logic [CNT_W-1:0]      r_avail;
  logic [IDX_W-1:0]      r_alloc_slot;
  logic                  r_spot;
  logic                  r_denied;
  logic                  r_leave_err;
  logic                  r_gate_open;
  logic                  r_full;
  logic                  r_empty;

  logic [NUM_SLOTS-1:0]  w_search_mask;
  logic [NUM_SLOTS-1:0]  w_cand;
  logic                  w_found;
  logic [IDX_W-1:0]      w_free_idx;
  logic                  w_grant;
  logic                  w_deny;
  logic [PAD_W-1:0]      w_occ_pad;
  logic [PAD_W-1:0]      w_clr_pad;
  logic                  w_rel_ok;
  logic                  w_leave_err;
  logic [NUM_SLOTS-1:0]  w_set;
  logic [NUM_SLOTS-1:0]  w_clr;
  logic [NUM_SLOTS-1:0]  w_occ_next;
  logic [CNT_W-1:0]      w_avail_next;

  // Slots a request is allowed to take; reserved slots open up with a permit.
  always_comb begin
    w_search_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
`ifdef CAR_PARK_RESERVE_EN
      w_search_mask[i] = (i < GEN_SLOTS) || i_car_permit;
`else
      w_search_mask[i] = (i < GEN_SLOTS);
`endif
    end
  end

  assign w_cand = ~r_occ & w_search_mask;

  // Scan from the top so the last hit is the lowest free index.
  always_comb begin
    w_found    = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_found    = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && i_car_enter && w_found;
  assign w_deny  = (r_state == S_IDLE) && i_car_enter && !w_found;

  // Pad the bitmap to a power of two so out-of-range indices read as free.
  assign w_occ_pad   = PAD_W'(r_occ);
  assign w_rel_ok    = i_car_leave && ({1'b0, i_leave_slot} < SLOT_LIM) && w_occ_pad[i_leave_slot];
  assign w_leave_err = i_car_leave && !w_rel_ok;

  assign w_clr_pad = PAD_W'(1) << i_leave_slot;
  assign w_set     = w_grant  ? (NUM_SLOTS'(1) << w_free_idx) : '0;
  assign w_clr     = w_rel_ok ? w_clr_pad[NUM_SLOTS-1:0]      : '0;

  // A granted slot is free pre-edge, so it can never also be a valid release.
  assign w_occ_next   = (r_occ | w_set) & ~w_clr;
  assign w_avail_next = r_avail - CNT_W'(w_grant) + CNT_W'(w_rel_ok);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_gate_cnt   <= '0;
      r_occ        <= '0;
      r_avail      <= ALL_FREE;
      r_alloc_slot <= '0;
      r_spot       <= 1'b0;
      r_denied     <= 1'b0;
      r_leave_err  <= 1'b0;
      r_gate_open  <= 1'b0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
    end else begin
      r_spot      <= 1'b0;
      r_denied    <= 1'b0;
      r_leave_err <= w_leave_err;
      r_occ       <= w_occ_next;
      r_avail     <= w_avail_next;
      r_full      <= (w_avail_next == '0);
      r_empty     <= (w_avail_next == ALL_FREE);

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_spot       <= 1'b1;
            r_alloc_slot <= w_free_idx;
            r_gate_open  <= 1'b1;
            r_gate_cnt   <= GATE_LOAD;
            r_state      <= S_GATE;
          end else if (w_deny) begin
            r_denied <= 1'b1;
            r_state  <= S_WAIT_CLR;
          end
        end
        S_GATE: begin
          // Terminal count: the gate has been open for GATE_CYCLES cycles.
          if (r_gate_cnt == GC_W'(1)) begin
            r_gate_open <= 1'b0;
            r_gate_cnt  <= '0;
            r_state     <= S_WAIT_CLR;
          end else begin
            r_gate_cnt <= r_gate_cnt - GC_W'(1);
          end
        end
        S_WAIT_CLR: begin
          if (!i_car_enter) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_gate_open <= 1'b0;
          r_gate_cnt  <= '0;
        end
      endcase
    end
  end

  assign o_spot_allocated  = r_spot;
  assign o_alloc_slot      = r_alloc_slot;
  assign o_enter_denied    = r_denied;
  assign o_leave_error     = r_leave_err;
  assign o_entry_gate_open = r_gate_open;
  assign o_available_slots = r_avail;
  assign o_parking_full    = r_full;
  assign o_parking_empty   = r_empty;
  assign o_occupancy       = r_occ;

endmodule

// File: tb/tb_car_park_allocator.sv
// Bench for car_park_allocator: directed scenarios with literal expectations,
// then a randomized phase; a behavioural model is compared on every cycle.

module tb_car_park_allocator;

  localparam int N  = 8;
  localparam int G  = 4;
  localparam int IW = 3;
  localparam int CW = 4;
`ifdef CAR_PARK_RESERVE_EN
  localparam int R  = 2;
`else
  localparam int R  = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          car_enter = 1'b0;
  logic          car_permit = 1'b0;
  logic          car_leave = 1'b0;
  logic [IW-1:0] leave_slot = '0;
  logic          spot_allocated;
  logic [IW-1:0] alloc_slot;
  logic          enter_denied;
  logic          leave_error;
  logic          entry_gate_open;
  logic [CW-1:0] available_slots;
  logic          parking_full;
  logic          parking_empty;
  logic [N-1:0]  occupancy;

  // Second, smaller instance for the non-power-of-two range check.
  logic          leave6 = 1'b0;
  logic [2:0]    slot6 = '0;
  logic          spot6, deny6, lerr6, gate6, full6, empty6;
  logic [2:0]    alloc6;
  logic [2:0]    avail6;
  logic [5:0]    occ6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  car_park_allocator #(.NUM_SLOTS(N), .GATE_CYCLES(G)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_car_enter(car_enter),
`ifdef CAR_PARK_RESERVE_EN
    .i_car_permit(car_permit),
`endif
    .i_car_leave(car_leave), .i_leave_slot(leave_slot),
    .o_spot_allocated(spot_allocated), .o_alloc_slot(alloc_slot),
    .o_enter_denied(enter_denied), .o_leave_error(leave_error),
    .o_entry_gate_open(entry_gate_open), .o_available_slots(available_slots),
    .o_parking_full(parking_full), .o_parking_empty(parking_empty),
    .o_occupancy(occupancy)
  );

  car_park_allocator #(.NUM_SLOTS(6), .GATE_CYCLES(2)) u_dut6 (
    .i_clk(clk), .i_reset(reset), .i_car_enter(1'b0),
`ifdef CAR_PARK_RESERVE_EN
    .i_car_permit(1'b0),
`endif
    .i_car_leave(leave6), .i_leave_slot(slot6),
    .o_spot_allocated(spot6), .o_alloc_slot(alloc6),
    .o_enter_denied(deny6), .o_leave_error(lerr6),
    .o_entry_gate_open(gate6), .o_available_slots(avail6),
    .o_parking_full(full6), .o_parking_empty(empty6),
    .o_occupancy(occ6)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [N-1:0] m_occ;
  int         m_gate_left;   // open cycles remaining, counting the current one
  bit         m_wait;        // request handled, waiting for car_enter to drop
  int         m_alloc;
  bit         m_spot, m_deny, m_lerr;

  function automatic int free_count(input bit [N-1:0] occ);
    int c = N;
    for (int i = 0; i < N; i++) if (occ[i]) c--;
    return c;
  endfunction

  task automatic model_step();
    bit [N-1:0] nxt;
    int         pick;
    if (reset) begin
      m_occ = '0; m_gate_left = 0; m_wait = 0; m_alloc = 0;
      m_spot = 0; m_deny = 0; m_lerr = 0;
      return;
    end
    m_spot = 0; m_deny = 0; m_lerr = 0;
    nxt = m_occ;
    if (m_gate_left > 0) begin
      m_gate_left--;
      if (m_gate_left == 0) m_wait = 1;
    end else if (m_wait) begin
      if (!car_enter) m_wait = 0;
    end else if (car_enter) begin
      pick = -1;
      for (int i = 0; i < N; i++)
        if (pick < 0 && !m_occ[i] && (i < N - R || car_permit)) pick = i;
      if (pick >= 0) begin
        nxt[pick] = 1'b1; m_alloc = pick; m_spot = 1; m_gate_left = G;
      end else begin
        m_deny = 1; m_wait = 1;
      end
    end
    if (car_leave) begin
      if (int'(leave_slot) < N && m_occ[leave_slot]) nxt[leave_slot] = 1'b0;
      else m_lerr = 1;
    end
    m_occ = nxt;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("spot_allocated",  spot_allocated,  m_spot);
    chk("alloc_slot",      alloc_slot,      m_alloc);
    chk("enter_denied",    enter_denied,    m_deny);
    chk("leave_error",     leave_error,     m_lerr);
    chk("entry_gate_open", entry_gate_open, m_gate_left > 0);
    chk("available_slots", available_slots, free_count(m_occ));
    chk("parking_full",    parking_full,    free_count(m_occ) == 0);
    chk("parking_empty",   parking_empty,   free_count(m_occ) == N);
    chk("occupancy",       occupancy,       m_occ);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic e, input logic l, input logic [IW-1:0] s);
    car_enter = e; car_leave = l; leave_slot = s;
    @(posedge clk);
    #2;
  endtask

  task automatic grant_and_settle();
    cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 0);
  endtask

  int spots;

  initial begin
    #2;
    reset = 1;
    cyc(0, 0, 0); cyc(0, 0, 0);
    chk("rst_avail", available_slots, 8);
    chk("rst_empty", parking_empty, 1);
    chk("rst_full",  parking_full, 0);
    chk("rst_occ",   occupancy, 8'h00);
    chk("rst_gate",  entry_gate_open, 0);
    chk("rst_alloc", alloc_slot, 0);
    reset = 0;
    cyc(0, 0, 0);

    // three spaced grants
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0);
      chk("s2_spot", spot_allocated, 1);
      chk("s2_alloc", alloc_slot, k);
      chk("s2_gate", entry_gate_open, 1);
      repeat (6) cyc(0, 0, 0);
    end
    chk("s2_occ", occupancy, 8'h07);
    chk("s2_avail", available_slots, 5);

    // release slot 1, then it is the lowest free slot again
    cyc(0, 1, 1);
    chk("s3_lerr", leave_error, 0);
    chk("s3_occ_rel", occupancy, 8'h05);
    cyc(1, 0, 0);
    chk("s3_alloc", alloc_slot, 1);
    chk("s3_occ", occupancy, 8'h07);
    repeat (6) cyc(0, 0, 0);

    // fill and deny
    repeat (5) grant_and_settle();
    chk("s4_occ_full", occupancy, 8'hFF);
    cyc(1, 0, 0);
    chk("s4_deny", enter_denied, 1);
    chk("s4_full", parking_full, 1);
    chk("s4_occ", occupancy, 8'hFF);
    chk("s4_gate", entry_gate_open, 0);
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(1, 1, 3);
    chk("s4_deny2", enter_denied, 1);
    chk("s4_occ2", occupancy, 8'hF7);
    chk("s4_avail2", available_slots, 1);
    cyc(0, 0, 0); cyc(0, 0, 0);

    // bad releases
    reset = 1; cyc(0, 0, 0); reset = 0;
    repeat (5) grant_and_settle();
    chk("s5_occ", occupancy, 8'h1F);
    leave6 = 1; slot6 = 3'd7;
    cyc(0, 1, 6);
    chk("s5_lerr", leave_error, 1);
    chk("s5_occ2", occupancy, 8'h1F);
    chk("s5_avail", available_slots, 3);
    chk("s5_lerr6", lerr6, 1);
    chk("s5_avail6", avail6, 6);
    slot6 = 3'd5;
    cyc(0, 0, 0);
    chk("s5_lerr6_free", lerr6, 1);
    leave6 = 0;
    cyc(0, 0, 0);
    chk("s5_lerr6_idle", lerr6, 0);

    // held request gives exactly one grant
    spots = 0;
    repeat (12) begin
      cyc(1, 0, 0);
      if (spot_allocated) spots++;
    end
    chk("s6_one_grant", spots, 1);
    chk("s6_occ", occupancy, 8'h3F);
    cyc(0, 0, 0); cyc(0, 0, 0);
    // grant and release together: freed slot 0 is not granted this cycle
    cyc(1, 1, 0);
    chk("s6_alloc", alloc_slot, 6);
    chk("s6_avail", available_slots, 2);
    chk("s6_occ2", occupancy, 8'h7E);
    repeat (6) cyc(0, 0, 0);

`ifdef CAR_PARK_RESERVE_EN
    reset = 1; cyc(0, 0, 0); reset = 0;
    car_permit = 0;
    repeat (6) grant_and_settle();
    chk("rsv_occ", occupancy, 8'h3F);
    cyc(1, 0, 0);
    chk("rsv_deny", enter_denied, 1);
    cyc(0, 0, 0); cyc(0, 0, 0);
    car_permit = 1;
    cyc(1, 0, 0);
    chk("rsv_alloc", alloc_slot, 6);
    car_permit = 0;
    repeat (6) cyc(0, 0, 0);
`endif

    // randomized phase, model checks every cycle
    for (int t = 0; t < 600; t++) begin
      reset      = ($urandom_range(0, 79) == 0);
      car_permit = $urandom_range(0, 1) == 1;
      cyc($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 4, IW'($urandom_range(0, 7)));
    end
    reset = 0;
    cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
